frame_sample_filter: RTL and testbench

- Streaming stage directly downstream of the data-processor register block. Consumes the parsed sample stream and applies the PS-selected algorithm (algorithmCode, filter1, filter2) to exactly dataCount samples per frame.
- Each frame is armed by the newDataFrame pulse and ends with a frameDone interrupt pulse.
- Sits under the AXI-Lite top level. Config and status ports are exposed as External/Interrupt signals.

---
 rtl/frame_sample_filter_pkg.sv | 21 ++
 rtl/frame_sample_filter_if.sv | 27 ++
 rtl/frame_sample_filter_sample_alu.sv | 49 ++++
 rtl/frame_sample_filter.sv | 207 ++++++++++++++++++++
 tb/tb_frame_sample_filter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_sample_filter_pkg.sv
// Shared definitions for the frame sample filter slice.
// Holds the algorithm codes, the frame FSM state encoding and the default
// widths used by the interface, the sample ALU and the top level.
package frame_sample_filter_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int COUNT_W_DEF = 32;
    localparam int DROP_W_DEF  = 16;

    localparam logic [3:0] ALG_PASS  = 4'd0;
    localparam logic [3:0] ALG_CLAMP = 4'd1;
    localparam logic [3:0] ALG_GATE  = 4'd2;
    localparam logic [3:0] ALG_DELTA = 4'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/frame_sample_filter_if.sv
// Sample stream interface: one valid/ready input channel and one
// valid/ready output channel.
//   in_valid/in_data/in_ready    : samples into the filter
//   out_valid/out_data/out_ready : filtered samples out of the filter
// slave  = the filter side, master = the producer/consumer side.
interface frame_sample_filter_if
    import frame_sample_filter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/frame_sample_filter_sample_alu.sv
// Combinational per-sample algorithm unit.
//   alg  : latched algorithm code (codes above 3 behave as pass)
//   lo   : lower band bound, hi : upper band bound (lo <= hi)
//   s    : current sample, prev : previous sample of this frame
//   r    : result sample, fwd : result should be forwarded downstream
module sample_alu
    import frame_sample_filter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [3:0]        alg,
    input  logic [DATA_W-1:0] lo,
    input  logic [DATA_W-1:0] hi,
    input  logic [DATA_W-1:0] s,
    input  logic [DATA_W-1:0] prev,
    output logic [DATA_W-1:0] r,
    output logic              fwd
);

    // Algorithm select; all comparisons are unsigned
    always_comb begin
        r   = s;
        fwd = 1'b1;
        case (alg)
            ALG_PASS: begin
                r   = s;
                fwd = 1'b1;
            end
            ALG_CLAMP: begin
                r   = (s < lo) ? lo : ((s > hi) ? hi : s);
                fwd = 1'b1;
            end
            ALG_GATE: begin
                r   = s;
                fwd = (s >= lo) && (s <= hi);
            end
            ALG_DELTA: begin
                // Wraps modulo 2^DATA_W by construction of the width
                r   = s - prev;
                fwd = 1'b1;
            end
            default: begin
                r   = s;
                fwd = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/frame_sample_filter.sv
// Frame-based sample filter. A newDataFrame pulse latches the algorithm,
// band bounds and frame length; exactly dataCount samples are then processed
// and the frame ends with a frameDone pulse.
// Ports:
//   clk, reset      : clock, synchronous active-low reset
//   newDataFrame    : arm pulse; errorClear : clears frameError/droppedCount
//   algorithmCode, filter1, filter2, dataCount : frame configuration
//   stream          : sample in/out valid-ready channels
//   busy            : frame in progress (RUN or FLUSH)
//   frameDone       : one-cycle end-of-frame pulse
//   passedCount     : samples forwarded in current/last frame
//   droppedCount    : saturating count of samples discarded while idle
//   frameError      : sticky, newDataFrame seen while busy
module frame_sample_filter
    import frame_sample_filter_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int COUNT_W = COUNT_W_DEF,
    parameter int DROP_W  = DROP_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 newDataFrame,
    input  logic                 errorClear,
    input  logic [3:0]           algorithmCode,
    input  logic [DATA_W-1:0]    filter1,
    input  logic [DATA_W-1:0]    filter2,
    input  logic [COUNT_W-1:0]   dataCount,
    frame_sample_filter_if.slave stream,
    output logic                 busy,
    output logic                 frameDone,
    output logic [COUNT_W-1:0]   passedCount,
    output logic [DROP_W-1:0]    droppedCount,
    output logic                 frameError
);

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          alg_r;
    logic [DATA_W-1:0]   lo_r;
    logic [DATA_W-1:0]   hi_r;
    logic [DATA_W-1:0]   prev_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic [COUNT_W-1:0]  target_r;
    logic [COUNT_W-1:0]  index_r;
    logic [COUNT_W-1:0]  passed_r;
    logic [DROP_W-1:0]   drop_r;
    logic                busy_r;
    logic                error_r;
    logic                zero_done_r;

    logic                in_ready_s;
    logic                in_accept_s;
    logic                out_take_s;
    logic                last_s;
    logic                arm_s;
    logic                flush_done_s;
    logic [DATA_W-1:0]   alu_r_s;
    logic                alu_fwd_s;

    assign arm_s       = (state_r == IDLE) && newDataFrame;
    assign in_accept_s = stream.in_valid && in_ready_s;
    assign out_take_s  = out_valid_r && stream.out_ready;
    // target is never zero while in RUN, so target-1 cannot underflow there
    assign last_s      = (index_r == (target_r - COUNT_W'(1)));

    sample_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .alg  (alg_r),
        .lo   (lo_r),
        .hi   (hi_r),
        .s    (stream.in_data),
        .prev (prev_r),
        .r    (alu_r_s),
        .fwd  (alu_fwd_s)
    );

    // Frame state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, input-ready and flush-completion decode
    always_comb begin
        state_s      = state_r;
        in_ready_s   = 1'b0;
        flush_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready_s = 1'b1;
                if (newDataFrame && (dataCount != {COUNT_W{1'b0}})) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                in_ready_s = !out_valid_r || stream.out_ready;
                if (stream.in_valid && in_ready_s && last_s) begin
                    state_s = FLUSH;
                end else begin
                    state_s = RUN;
                end
            end
            FLUSH: begin
                in_ready_s = 1'b0;
                // Frame ends in the same cycle the last result leaves
                if (!out_valid_r || stream.out_ready) begin
                    flush_done_s = 1'b1;
                    state_s      = IDLE;
                end else begin
                    state_s = FLUSH;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Frame configuration latch, sample index and delta history
    always_ff @(posedge clk) begin
        if (!reset) begin
            alg_r    <= 4'd0;
            lo_r     <= {DATA_W{1'b0}};
            hi_r     <= {DATA_W{1'b0}};
            target_r <= {COUNT_W{1'b0}};
            index_r  <= {COUNT_W{1'b0}};
            prev_r   <= {DATA_W{1'b0}};
        end else if (arm_s) begin
            alg_r    <= algorithmCode;
            lo_r     <= (filter1 < filter2) ? filter1 : filter2;
            hi_r     <= (filter1 < filter2) ? filter2 : filter1;
            target_r <= dataCount;
            index_r  <= {COUNT_W{1'b0}};
            prev_r   <= {DATA_W{1'b0}};
        end else if ((state_r == RUN) && in_accept_s) begin
            index_r  <= index_r + COUNT_W'(1);
            prev_r   <= stream.in_data;
        end
    end

    // Output register and forwarded-sample counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_data_r  <= {DATA_W{1'b0}};
            out_valid_r <= 1'b0;
            passed_r    <= {COUNT_W{1'b0}};
        end else begin
            if ((state_r == RUN) && in_accept_s && alu_fwd_s) begin
                out_data_r  <= alu_r_s;
                out_valid_r <= 1'b1;
            end else if (out_take_s) begin
                out_valid_r <= 1'b0;
            end
            if (arm_s) begin
                passed_r <= {COUNT_W{1'b0}};
            end else if ((state_r == RUN) && in_accept_s && alu_fwd_s) begin
                passed_r <= passed_r + COUNT_W'(1);
            end
        end
    end

    // Status: busy flag, zero-length done pulse, drop counter, sticky error
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_r      <= 1'b0;
            zero_done_r <= 1'b0;
            drop_r      <= {DROP_W{1'b0}};
            error_r     <= 1'b0;
        end else begin
            busy_r      <= (state_s != IDLE);
            zero_done_r <= arm_s && (dataCount == {COUNT_W{1'b0}});
            // A clear in the same cycle as a drop wins over the increment
            if (errorClear) begin
                drop_r <= {DROP_W{1'b0}};
            end else if ((state_r == IDLE) && in_accept_s &&
                         (drop_r != {DROP_W{1'b1}})) begin
                drop_r <= drop_r + DROP_W'(1);
            end
            // A new error in the same cycle as a clear wins over the clear
            if (newDataFrame && (state_r != IDLE)) begin
                error_r <= 1'b1;
            end else if (errorClear) begin
                error_r <= 1'b0;
            end
        end
    end

    assign stream.in_ready  = in_ready_s;
    assign stream.out_valid = out_valid_r;
    assign stream.out_data  = out_data_r;
    assign busy             = busy_r;
    // Zero-length frames finish one cycle after arming; normal frames finish
    // in the cycle of the final output handshake.
    assign frameDone        = zero_done_r || flush_done_s;
    assign passedCount      = passed_r;
    assign droppedCount     = drop_r;
    assign frameError       = error_r;

endmodule

// File: tb/tb_frame_sample_filter.sv
module tb_frame_sample_filter;

    logic        clk = 1'b0;
    logic        reset;
    logic        newDataFrame;
    logic        errorClear;
    logic [3:0]  algorithmCode;
    logic [15:0] filter1;
    logic [15:0] filter2;
    logic [31:0] dataCount;
    logic        busy;
    logic        frameDone;
    logic [31:0] passedCount;
    logic [15:0] droppedCount;
    logic        frameError;

    frame_sample_filter_if #(.DATA_W(16)) bus ();

    frame_sample_filter #(.DATA_W(16), .COUNT_W(32), .DROP_W(16)) dut (
        .clk           (clk),
        .reset         (reset),
        .newDataFrame  (newDataFrame),
        .errorClear    (errorClear),
        .algorithmCode (algorithmCode),
        .filter1       (filter1),
        .filter2       (filter2),
        .dataCount     (dataCount),
        .stream        (bus),
        .busy          (busy),
        .frameDone     (frameDone),
        .passedCount   (passedCount),
        .droppedCount  (droppedCount),
        .frameError    (frameError)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] stim_q[$];
    logic [15:0] exp_q[$];
    logic [15:0] obs_q[$];
    int          acc_cyc[$];
    int          take_cyc[$];
    int          done_pulses, done_cycle, extra_done, stab_viol, flush_viol;
    bit          timed_out;

    // Reference: expected output list of a frame from the algorithm rules.
    function automatic void model_frame(input logic [3:0] alg, input logic [15:0] f1,
                                        input logic [15:0] f2);
        logic [15:0] lo, hi, pv, s;
        exp_q.delete();
        lo = (f1 < f2) ? f1 : f2;
        hi = (f1 < f2) ? f2 : f1;
        pv = 16'd0;
        foreach (stim_q[i]) begin
            s = stim_q[i];
            case (alg)
                4'd1: exp_q.push_back((s < lo) ? lo : ((s > hi) ? hi : s));
                4'd2: if (s >= lo && s <= hi) exp_q.push_back(s);
                4'd3: begin exp_q.push_back(s - pv); pv = s; end
                default: exp_q.push_back(s);
            endcase
        end
    endfunction

    // Drives one frame of stim_q and records what the DUT did.
    task automatic run_frame(input logic [3:0] alg, input logic [15:0] f1, input logic [15:0] f2,
                             input int rdy_pct, input int vld_pct, input bit hold_last,
                             input bit mid_ndf);
        int sent, cyc, hold_cnt;
        bit done, prev_stall, acc, take;
        logic [15:0] prev_data;
        logic [31:0] cnt;
        cnt = stim_q.size();
        obs_q.delete(); acc_cyc.delete(); take_cyc.delete();
        done_pulses = 0; done_cycle = -1; extra_done = 0; stab_viol = 0; flush_viol = 0;
        timed_out = 0; sent = 0; cyc = 0; hold_cnt = 0; done = 0; prev_stall = 0;
        prev_data = 16'd0;
        @(negedge clk);
        bus.in_valid = 1'b0; newDataFrame = 1'b1; errorClear = 1'b0;
        algorithmCode = alg; filter1 = f1; filter2 = f2; dataCount = cnt;
        @(negedge clk);
        newDataFrame = 1'b0;
        algorithmCode = 4'($urandom); filter1 = 16'($urandom); filter2 = 16'($urandom);
        dataCount = $urandom;
        while (!done && cyc < 400) begin
            newDataFrame = 1'b0; errorClear = 1'b0;
            if (mid_ndf && cyc == 2) begin newDataFrame = 1'b1; errorClear = 1'b1; end
            bus.in_valid = (sent < stim_q.size()) && ($urandom_range(99) < vld_pct);
            if (bus.in_valid) bus.in_data = stim_q[sent];
            else bus.in_data = 16'($urandom);
            bus.out_ready = ($urandom_range(99) < rdy_pct);
            if (hold_last && sent == stim_q.size() && bus.out_valid && hold_cnt < 3) begin
                bus.out_ready = 1'b0; hold_cnt++;
            end
            #1;
            if (prev_stall && (!bus.out_valid || bus.out_data !== prev_data)) stab_viol++;
            if (cnt != 0 && sent == stim_q.size() && bus.in_ready) flush_viol++;
            acc  = bus.in_valid && bus.in_ready;
            take = bus.out_valid && bus.out_ready;
            if (acc) begin acc_cyc.push_back(cyc); sent++; end
            if (take) begin obs_q.push_back(bus.out_data); take_cyc.push_back(cyc); end
            if (frameDone) begin done_pulses++; done_cycle = cyc; done = 1; end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            @(negedge clk);
            cyc++;
        end
        if (!done) timed_out = 1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1; newDataFrame = 1'b0; errorClear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            if (frameDone) extra_done++;
            @(negedge clk);
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; newDataFrame = 1'b0; errorClear = 1'b0; algorithmCode = 4'd0;
        filter1 = 16'd0; filter2 = 16'd0; dataCount = 32'd0;
        bus.in_valid = 1'b0; bus.in_data = 16'd0; bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data got %0h want 0", bus.out_data); end
        checks++; if (busy !== 1'b0 || frameDone !== 1'b0 || frameError !== 1'b0) begin errors++; $display("FAIL reset_flags got busy=%0b done=%0b err=%0b want 000", busy, frameDone, frameError); end
        checks++; if (passedCount !== 32'd0 || droppedCount !== 16'd0) begin errors++; $display("FAIL reset_counts got %0d/%0d want 0/0", passedCount, droppedCount); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready got %0b want 1", bus.in_ready); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_pass();
        logic [15:0] want[$] = '{16'd10, 16'd20, 16'd30, 16'd40};
        stim_q = '{16'd10, 16'd20, 16'd30, 16'd40};
        run_frame(4'd0, 16'd0, 16'd0, 100, 100, 0, 0);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL pass_timeout got %0b want 0", timed_out); end
        checks++; if (obs_q.size() !== want.size()) begin errors++; $display("FAIL pass_count got %0d want %0d", obs_q.size(), want.size()); end
        foreach (want[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== want[i]) begin errors++; $display("FAIL pass_data[%0d] got %0d want %0d", i, obs_q[i], want[i]); end
            checks++; if (take_cyc[i] !== acc_cyc[i] + 1) begin errors++; $display("FAIL pass_latency[%0d] got %0d want %0d", i, take_cyc[i] - acc_cyc[i], 1); end
        end
        checks++; if (passedCount !== 32'd4) begin errors++; $display("FAIL pass_passed got %0d want 4", passedCount); end
        checks++; if (done_pulses !== 1 || extra_done !== 0) begin errors++; $display("FAIL pass_done_pulses got %0d+%0d want 1+0", done_pulses, extra_done); end
        checks++; if (take_cyc.size() == 0 || done_cycle !== take_cyc[$]) begin errors++; $display("FAIL pass_done_cycle got %0d want last take", done_cycle); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pass_busy_fall got %0b want 0", busy); end
    endtask

    task automatic test_clamp();
        logic [15:0] want[$] = '{16'd100, 16'd150, 16'd200};
        stim_q = '{16'd50, 16'd150, 16'd250};
        run_frame(4'd1, 16'd200, 16'd100, 100, 100, 0, 0);
        checks++; if (obs_q.size() !== want.size() || timed_out) begin errors++; $display("FAIL clamp_count got %0d want %0d", obs_q.size(), want.size()); end
        foreach (want[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== want[i]) begin errors++; $display("FAIL clamp_data[%0d] got %0d want %0d", i, obs_q[i], want[i]); end
        end
    endtask

    task automatic test_gate();
        logic [15:0] want[$] = '{16'd100, 16'd200, 16'd150};
        stim_q = '{16'd99, 16'd100, 16'd200, 16'd201, 16'd150};
        run_frame(4'd2, 16'd100, 16'd200, 100, 100, 0, 0);
        checks++; if (obs_q.size() !== want.size() || timed_out) begin errors++; $display("FAIL gate_count got %0d want %0d", obs_q.size(), want.size()); end
        foreach (want[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== want[i]) begin errors++; $display("FAIL gate_data[%0d] got %0d want %0d", i, obs_q[i], want[i]); end
        end
        checks++; if (passedCount !== 32'd3) begin errors++; $display("FAIL gate_passed got %0d want 3", passedCount); end
        checks++; if (acc_cyc.size() !== 5 || done_pulses !== 1) begin errors++; $display("FAIL gate_accepts got %0d/%0d want 5/1", acc_cyc.size(), done_pulses); end
    endtask

    task automatic test_delta();
        logic [15:0] want[$] = '{16'h0005, 16'hFFFE, 16'hFFFC};
        stim_q = '{16'd5, 16'd3, 16'hFFFF};
        run_frame(4'd3, 16'd0, 16'd0, 100, 100, 0, 0);
        checks++; if (obs_q.size() !== want.size() || timed_out) begin errors++; $display("FAIL delta_count got %0d want %0d", obs_q.size(), want.size()); end
        foreach (want[i]) if (i < obs_q.size()) begin
            checks++; if (obs_q[i] !== want[i]) begin errors++; $display("FAIL delta_data[%0d] got %0h want %0h", i, obs_q[i], want[i]); end
        end
    endtask

    task automatic test_backpressure();
        stim_q = '{16'd7, 16'd8, 16'd9};
        model_frame(4'd0, 16'd0, 16'd0);
        run_frame(4'd0, 16'd0, 16'd0, 100, 100, 1, 0);
        checks++; if (obs_q !== exp_q || timed_out) begin errors++; $display("FAIL bp_data got %0d items want %0d", obs_q.size(), exp_q.size()); end
        checks++; if (stab_viol !== 0) begin errors++; $display("FAIL bp_stable got %0d want 0", stab_viol); end
        checks++; if (flush_viol !== 0) begin errors++; $display("FAIL bp_flush_ready got %0d want 0", flush_viol); end
        checks++; if (done_pulses !== 1 || extra_done !== 0 || take_cyc.size() == 0 || done_cycle !== take_cyc[$]) begin errors++; $display("FAIL bp_done got %0d pulses at %0d want 1 at last take", done_pulses, done_cycle); end
        // Samples while idle are dropped
        @(negedge clk); errorClear = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk); errorClear = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'd1;
        @(negedge clk);
        @(negedge clk); bus.in_valid = 1'b0;
        #1;
        checks++; if (droppedCount !== 16'd2) begin errors++; $display("FAIL idle_drop got %0d want 2", droppedCount); end
        @(negedge clk); errorClear = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk); errorClear = 1'b0; bus.in_valid = 1'b0;
        #1;
        checks++; if (droppedCount !== 16'd0) begin errors++; $display("FAIL drop_clear_wins got %0d want 0", droppedCount); end
    endtask

    task automatic test_errors();
        stim_q = '{16'd300, 16'd50, 16'd120, 16'd999, 16'd180, 16'd10};
        model_frame(4'd1, 16'd100, 16'd200);
        run_frame(4'd1, 16'd100, 16'd200, 100, 100, 0, 1);
        checks++; if (frameError !== 1'b1) begin errors++; $display("FAIL err_set got %0b want 1", frameError); end
        checks++; if (obs_q !== exp_q || timed_out || done_pulses !== 1) begin errors++; $display("FAIL err_frame_unchanged got %0d items want %0d", obs_q.size(), exp_q.size()); end
        @(negedge clk); errorClear = 1'b1;
        @(negedge clk); errorClear = 1'b0;
        #1;
        checks++; if (frameError !== 1'b0) begin errors++; $display("FAIL err_clear got %0b want 0", frameError); end
    endtask

    task automatic test_zero();
        stim_q.delete();
        run_frame(4'd0, 16'd0, 16'd0, 100, 100, 0, 0);
        checks++; if (done_pulses !== 1 || extra_done !== 0 || timed_out) begin errors++; $display("FAIL zero_done got %0d+%0d want 1+0", done_pulses, extra_done); end
        checks++; if (done_cycle !== 0) begin errors++; $display("FAIL zero_done_cycle got %0d want 0", done_cycle); end
        checks++; if (obs_q.size() !== 0 || busy !== 1'b0) begin errors++; $display("FAIL zero_outputs got %0d busy=%0b want 0 0", obs_q.size(), busy); end
    endtask

    task automatic test_random();
        logic [3:0] alg; logic [15:0] f1, f2; int n;
        for (int f = 0; f < 10; f++) begin
            alg = 4'($urandom_range(0, 15));
            f1 = 16'($urandom_range(0, 1000)); f2 = 16'($urandom_range(0, 1000));
            n = $urandom_range(1, 12);
            stim_q.delete();
            for (int i = 0; i < n; i++)
                stim_q.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 1200)));
            model_frame(alg, f1, f2);
            run_frame(alg, f1, f2, 60, 70, 0, 0);
            checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout got 1 want 0", f); end
            checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", f, obs_q.size(), exp_q.size()); end
            foreach (exp_q[i]) if (i < obs_q.size()) begin
                checks++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd%0d_data[%0d] alg=%0d got %0h want %0h", f, i, alg, obs_q[i], exp_q[i]); end
            end
            checks++; if (passedCount !== 32'(exp_q.size())) begin errors++; $display("FAIL rnd%0d_passed got %0d want %0d", f, passedCount, exp_q.size()); end
            checks++; if (done_pulses !== 1 || extra_done !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rnd%0d_done got %0d+%0d busy=%0b want 1+0 0", f, done_pulses, extra_done, busy); end
            checks++; if (stab_viol !== 0 || flush_viol !== 0) begin errors++; $display("FAIL rnd%0d_handshake got %0d/%0d want 0/0", f, stab_viol, flush_viol); end
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        @(negedge clk);
        newDataFrame = 1'b1; algorithmCode = 4'd0; filter1 = 16'd0; filter2 = 16'd0;
        dataCount = 32'd10; bus.out_ready = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk); newDataFrame = 1'b0; bus.in_valid = 1'b1; bus.in_data = 16'h1234;
        @(negedge clk); bus.in_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || bus.out_valid !== 1'b1 || passedCount !== 32'd1) begin errors++; $display("FAIL rst_mid_pre got busy=%0b ov=%0b pc=%0d want 1 1 1", busy, bus.out_valid, passedCount); end
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.out_data !== 16'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_out got ov=%0b od=%0h busy=%0b want 0 0 0", bus.out_valid, bus.out_data, busy); end
        checks++; if (passedCount !== 32'd0 || droppedCount !== 16'd0 || frameError !== 1'b0 || frameDone !== 1'b0) begin errors++; $display("FAIL rst_mid_status got pc=%0d dc=%0d err=%0b done=%0b want 0", passedCount, droppedCount, frameError, frameDone); end
        reset = 1'b1; bus.out_ready = 1'b1; seen = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (frameDone) seen++;
        end
        checks++; if (seen !== 0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_no_done got %0d busy=%0b want 0 0", seen, busy); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_clamp();
        test_gate();
        test_delta();
        test_backpressure();
        test_errors();
        test_zero();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
